// File: rtl/tiny_cache_responder_if.sv
// CPU-bus bundle between the transaction initiator and tiny_cache_responder.
// Request fields are sampled with go; response fields are valid while done is high.
interface tiny_cache_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              go;
  logic              transaction_req;
  logic [ADDR_W-1:0] cpubus_address;
  logic [DATA_W-1:0] cpubus_data_in;
  logic [DATA_W-1:0] cpubus_data_out;
  logic              done;
  logic              cache_hit;

  modport master (
    output go,
    output transaction_req,
    output cpubus_address,
    output cpubus_data_in,
    input  cpubus_data_out,
    input  done,
    input  cache_hit
  );

  modport slave (
    input  go,
    input  transaction_req,
    input  cpubus_address,
    input  cpubus_data_in,
    output cpubus_data_out,
    output done,
    output cache_hit
  );
endinterface

// File: rtl/tiny_cache_responder.sv
// Go/done bus responder with a direct-mapped, write-through, no-write-allocate cache
// in front of a fixed-latency backing memory.
module tiny_cache_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned INDEX_W     = 3,
  parameter int unsigned MEM_LATENCY = 4
) (
  input logic                   clk,
  input logic                   rst,
  tiny_cache_responder_if.slave bus
);
  localparam int unsigned TagW     = ADDR_W - INDEX_W;
  localparam int unsigned Lines    = 2 ** INDEX_W;
  localparam int unsigned MemDepth = 2 ** ADDR_W;
  localparam int unsigned CntW     = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {StIdle, StLookup, StMem, StResp, StRelease} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              chit_q, chit_d;

  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [DATA_W-1:0] line_q [Lines];
  logic [DATA_W-1:0] mem_q  [MemDepth];

  logic [INDEX_W-1:0] idx;
  logic [TagW-1:0]    tag;
  logic               lookup_hit;
  logic               fill_en, line_we, mem_we;

  assign idx        = addr_q[INDEX_W-1:0];
  assign tag        = addr_q[ADDR_W-1:INDEX_W];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hit_d   = hit_q;
    rdata_d = rdata_q;
    chit_d  = chit_q;
    fill_en = 1'b0;
    line_we = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          req_d   = bus.transaction_req;
          addr_d  = bus.cpubus_address;
          wdata_d = bus.cpubus_data_in;
          state_d = StLookup;
        end
      end
      StLookup: begin
        hit_d = lookup_hit;
        if (!req_q && lookup_hit) begin
          rdata_d = line_q[idx];
          chit_d  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = CntW'(MEM_LATENCY - 1);
          state_d = StMem;
        end
      end
      StMem: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          if (req_q) begin
            // Write-through: memory always updated, the line only if it was resident.
            mem_we  = 1'b1;
            line_we = hit_q;
            rdata_d = wdata_q;
            chit_d  = hit_q;
          end else begin
            fill_en = 1'b1;
            rdata_d = mem_q[addr_q];
            chit_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (!bus.go) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      chit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      chit_q  <= chit_d;
    end
  end

  // Backing memory comes out of reset holding the bitwise inverse of each address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < Lines; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
      for (int i = 0; i < MemDepth; i++) begin
        mem_q[i] <= DATA_W'(~ADDR_W'(i));
      end
    end else begin
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= tag;
        line_q[idx]  <= mem_q[addr_q];
      end
      if (line_we) line_q[idx] <= wdata_q;
      if (mem_we) mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.done            = (state_q == StResp);
  assign bus.cpubus_data_out = rdata_q;
  assign bus.cache_hit       = chit_q;

endmodule
